// File: rtl/timestable_pkg.sv
// Shared types and address helper for the times-table AXI4-Lite reader.
package timestable_pkg;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Byte address of table entry {b,a}: one 32-bit word per entry.
  function automatic logic [63:0] table_addr(input logic [63:0] base,
                                             input logic [31:0] a,
                                             input logic [31:0] b,
                                             input int          op_w);
    return base + ((((64'(b)) << op_w) | 64'(a)) << 2);
  endfunction

endpackage

// File: rtl/axil_read_ch.sv
// Single-beat AXI4-Lite read engine: start with addr, one-cycle done with data/resp.
// Minimum 3 cycles start->done; AR and R stalls stretch it; start ignored while a read is open.
module axil_read_ch #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  output logic              done,
  output logic [DATA_W-1:0] data,
  output logic [1:0]        resp,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);

  always_ff @(posedge clk) begin
    if (rst) begin
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      done          <= 1'b0;
      data          <= '0;
      resp          <= 2'b00;
    end else begin
      done <= 1'b0;
      if (start && !m_axi_arvalid && !m_axi_rready) begin
        m_axi_araddr  <= addr;
        m_axi_arvalid <= 1'b1;
      end
      // araddr is left untouched on the handshake so it stays stable for the slave
      if (m_axi_arvalid && m_axi_arready) begin
        m_axi_arvalid <= 1'b0;
        m_axi_rready  <= 1'b1;
      end
      if (m_axi_rready && m_axi_rvalid) begin
        m_axi_rready <= 1'b0;
        done         <= 1'b1;
        data         <= m_axi_rdata;
        resp         <= m_axi_rresp;
      end
    end
  end

endmodule

// File: rtl/timestable_axil_reader.sv
// Fetches a*b from an AXI4-Lite table slave: done 4 cycles after req minimum, slave stalls extend it.
// req ignored while busy; optional TIMESTABLE_SELFCHECK_EN adds mismatch/mismatch_seen outputs.
module timestable_axil_reader
  import timestable_pkg::*;
#(
  parameter int                OP_W      = 3,
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [2*OP_W-1:0] result,
  output logic              err,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
`ifdef TIMESTABLE_SELFCHECK_EN
  ,
  output logic              mismatch,
  output logic              mismatch_seen
`endif
);

  localparam int RES_W = 2 * OP_W;

  state_t              state, state_nxt;
  logic                ch_start;
  logic                ch_done;
  logic [DATA_W-1:0]   ch_data;
  logic [1:0]          ch_resp;
  logic [ADDR_W-1:0]   req_addr;

  assign req_addr = ADDR_W'(table_addr(64'(BASE_ADDR), 32'(a), 32'(b), OP_W));

  axil_read_ch #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_rd (
    .clk           (clk),
    .rst           (rst),
    .start         (ch_start),
    .addr          (req_addr),
    .done          (ch_done),
    .data          (ch_data),
    .resp          (ch_resp),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ch_start  = 1'b0;
    unique case (state)
      IDLE: if (req) begin
        ch_start  = 1'b1;
        state_nxt = ADDR;
      end
      ADDR: if (m_axi_arvalid && m_axi_arready) state_nxt = DATA;
      DATA: if (ch_done) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      err    <= 1'b0;
    end else if (ch_done) begin
      result <= ch_data[RES_W-1:0];
      err    <= (ch_resp != RESP_OKAY);
    end
  end

`ifdef TIMESTABLE_SELFCHECK_EN
  logic [OP_W-1:0]  a_cap, b_cap;
  logic [RES_W-1:0] prod;
  logic             mis_nxt;

  assign prod    = RES_W'(a_cap) * RES_W'(b_cap);
  // An error response carries no trustworthy data, so it never flags a mismatch.
  assign mis_nxt = (ch_resp == RESP_OKAY) && (ch_data[RES_W-1:0] != prod);

  always_ff @(posedge clk) begin
    if (rst) begin
      a_cap         <= '0;
      b_cap         <= '0;
      mismatch      <= 1'b0;
      mismatch_seen <= 1'b0;
    end else begin
      if (ch_start) begin
        a_cap <= a;
        b_cap <= b;
      end
      if (ch_done) begin
        mismatch      <= mis_nxt;
        mismatch_seen <= mismatch_seen | mis_nxt;
      end
    end
  end
`endif

endmodule
